// File: rtl/dram_write_packer.sv
// rtl/dram_write_packer.sv - coalesces 16-bit addressed word writes into 128-bit DRAM line beats with byte strobes
module dram_write_packer #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic [15:0]  s_axis_tdata,
   input  logic [23:0]  s_axis_taddr,
   input  logic         flush,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [127:0] m_axis_tdata,
   output logic [20:0]  m_axis_taddr,
   output logic [15:0]  m_axis_tstrb,
   output logic [15:0]  lines_emitted
);

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_EMIT} state_t;

   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   state_t        r_state;
   state_t        w_next;
   logic [127:0]  r_buf;
   logic [20:0]   r_line_addr;
   logic [7:0]    r_mask;
   logic [15:0]   r_timer;
   logic [15:0]   r_lines;

   logic          w_same_line;
   logic          w_accept;
   logic [7:0]    w_word_bit;
   logic [6:0]    w_word_lsb;
   logic          w_timer_exp;
   logic          w_line_full;

   assign w_same_line = (s_axis_taddr[23:3] == r_line_addr);
   assign w_accept    = s_axis_tvalid & s_axis_tready;
   assign w_word_bit  = 8'd1 << s_axis_taddr[2:0];
   assign w_word_lsb  = {s_axis_taddr[2:0], 4'b0000};
   assign w_timer_exp = (r_timer == TIMEOUT_M1);
   assign w_line_full = ((r_mask | w_word_bit) == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // Flush outranks a mismatching word, which outranks a completing accept.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) w_next = S_FILL;
         end
         S_FILL: begin
            if (flush)
               w_next = S_EMIT;
            else if (s_axis_tvalid && !w_same_line)
               w_next = S_EMIT;
            else if (w_accept && w_line_full)
               w_next = S_EMIT;
            else if (!w_accept && w_timer_exp)
               w_next = S_EMIT;
         end
         S_EMIT: begin
            if (m_axis_tready) w_next = S_EMPTY;
         end
         default: w_next = S_EMPTY;
      endcase
   end

   always_comb begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      case (r_state)
         S_EMPTY: s_axis_tready = !rst;
         S_FILL:  s_axis_tready = !rst && w_same_line && !flush;
         S_EMIT:  m_axis_tvalid = 1'b1;
         default: begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf       <= '0;
         r_line_addr <= '0;
         r_mask      <= '0;
         r_timer     <= '0;
         r_lines     <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_line_addr             <= s_axis_taddr[23:3];
                  r_buf[w_word_lsb +: 16] <= s_axis_tdata;
                  r_mask                  <= w_word_bit;
                  r_timer                 <= '0;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_buf[w_word_lsb +: 16] <= s_axis_tdata;
                  r_mask                  <= r_mask | w_word_bit;
                  r_timer                 <= '0;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            S_EMIT: begin
               if (m_axis_tready) begin
                  r_buf   <= '0;
                  r_mask  <= '0;
                  r_lines <= r_lines + 16'd1;
               end
            end
            default: begin
               r_mask <= '0;
            end
         endcase
      end
   end

   assign m_axis_tdata  = r_buf;
   assign m_axis_taddr  = r_line_addr;
   assign lines_emitted = r_lines;

   for (genvar gi = 0; gi < 8; gi++) begin : g_strb
      assign m_axis_tstrb[2*gi +: 2] = {2{r_mask[gi]}};
   end

endmodule

// File: tb/tb_dram_write_packer.sv
// tb/tb_dram_write_packer.sv - directed self-checking bench for dram_write_packer
module tb_dram_write_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [15:0]  s_axis_tdata;
   logic [23:0]  s_axis_taddr;
   logic         flush;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic [127:0] m_axis_tdata;
   logic [20:0]  m_axis_taddr;
   logic [15:0]  m_axis_tstrb;
   logic [15:0]  lines_emitted;

   int checks = 0;
   int passed = 0;
   int beats  = 0;

   dram_write_packer #(.TIMEOUT(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_taddr  (s_axis_taddr),
      .flush         (flush),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_taddr  (m_axis_taddr),
      .m_axis_tstrb  (m_axis_tstrb),
      .lines_emitted (lines_emitted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) beats++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [23:0] a, input logic [15:0] d);
      s_axis_tvalid = v;
      s_axis_taddr  = a;
      s_axis_tdata  = d;
   endtask

   initial begin
      logic         stable;
      logic [127:0] hold_data;
      int           beats_before;

      rst = 1'b1;
      flush = 1'b0;
      m_axis_tready = 1'b1;
      drive(1'b0, 24'h0, 16'h0);
      #1;
      check("rst_s_tready", 128'(s_axis_tready), 128'd0);

      // 1: reset and idle
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_s_tready_cyc", 128'(s_axis_tready), 128'd0);
      end
      check("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
      check("rst_tdata", m_axis_tdata, 128'd0);
      check("rst_taddr", 128'(m_axis_taddr), 128'd0);
      check("rst_tstrb", 128'(m_axis_tstrb), 128'd0);
      check("rst_lines", 128'(lines_emitted), 128'd0);
      rst = 1'b0;
      #1;
      check("post_rst_s_tready", 128'(s_axis_tready), 128'd1);
      for (int i = 0; i < 200; i++) tick();
      check("idle_beats", 128'(beats), 128'd0);

      // 2: full burst
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 24'h10 + 24'(i), 16'h1000 + 16'(i));
         tick();
      end
      drive(1'b1, 24'h18, 16'h1008);
      #1;
      check("burst_tvalid", 128'(m_axis_tvalid), 128'd1);
      check("burst_tdata", m_axis_tdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
      check("burst_taddr", 128'(m_axis_taddr), 128'h2);
      check("burst_tstrb", 128'(m_axis_tstrb), 128'hFFFF);
      check("burst_emit_s_tready", 128'(s_axis_tready), 128'd0);
      tick();
      check("burst_lines", 128'(lines_emitted), 128'd1);
      check("burst_beats", 128'(beats), 128'd1);
      check("burst_next_ready", 128'(s_axis_tready), 128'd1);
      tick();
      drive(1'b0, 24'h0, 16'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("burst_tail_taddr", 128'(m_axis_taddr), 128'h3);
      check("burst_tail_tdata", m_axis_tdata, 128'h1008);
      check("burst_tail_tstrb", 128'(m_axis_tstrb), 128'h0003);
      tick();

      // 3: overwrite and line switch
      drive(1'b1, 24'h20, 16'hAAAA); tick();
      drive(1'b1, 24'h21, 16'hBBBB); tick();
      drive(1'b1, 24'h20, 16'hCCCC); tick();
      drive(1'b1, 24'h40, 16'h1234);
      #1;
      check("switch_mismatch_ready", 128'(s_axis_tready), 128'd0);
      tick();
      check("switch_tvalid", 128'(m_axis_tvalid), 128'd1);
      check("switch_taddr", 128'(m_axis_taddr), 128'h4);
      check("switch_tdata", m_axis_tdata, 128'hBBBB_CCCC);
      check("switch_tstrb", 128'(m_axis_tstrb), 128'h000F);
      check("switch_held", 128'(s_axis_tready), 128'd0);
      tick();
      check("switch_empty_ready", 128'(s_axis_tready), 128'd1);
      tick();
      drive(1'b0, 24'h0, 16'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("switch2_taddr", 128'(m_axis_taddr), 128'h8);
      check("switch2_tstrb", 128'(m_axis_tstrb), 128'h0003);
      check("switch2_tdata", m_axis_tdata, 128'h1234);
      tick();
      check("switch_lines", 128'(lines_emitted), 128'd4);

      // 4: timeout (TIMEOUT=16), tready held low for the backpressure step
      m_axis_tready = 1'b0;
      drive(1'b1, 24'h05, 16'h5555);
      tick();
      drive(1'b0, 24'h0, 16'h0);
      for (int i = 0; i < 15; i++) tick();
      check("timeout_early", 128'(m_axis_tvalid), 128'd0);
      tick();
      check("timeout_tvalid", 128'(m_axis_tvalid), 128'd1);
      check("timeout_tstrb", 128'(m_axis_tstrb), 128'h0C00);
      check("timeout_tdata", m_axis_tdata, 128'h5555 << 80);

      // 5: backpressure
      drive(1'b1, 24'h30, 16'h7777);
      hold_data = m_axis_tdata;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_data || m_axis_taddr !== 21'h0 ||
             m_axis_tstrb !== 16'h0C00 || s_axis_tready !== 1'b0)
            stable = 1'b0;
      end
      check("bp_stable", 128'(stable), 128'd1);
      check("bp_lines", 128'(lines_emitted), 128'd4);
      m_axis_tready = 1'b1;
      tick();
      check("bp_lines_after", 128'(lines_emitted), 128'd5);
      check("bp_one_beat", 128'(beats), 128'd5);
      tick();
      drive(1'b0, 24'h0, 16'h0);

      // 6a: flush outranks a same-line word
      drive(1'b1, 24'h31, 16'h8888);
      flush = 1'b1;
      #1;
      check("flush_prio_ready", 128'(s_axis_tready), 128'd0);
      tick();
      flush = 1'b0;
      check("flush_tdata", m_axis_tdata, 128'h7777);
      check("flush_tstrb", 128'(m_axis_tstrb), 128'h0003);
      check("flush_taddr", 128'(m_axis_taddr), 128'h6);
      tick();
      check("flush_ready_after", 128'(s_axis_tready), 128'd1);
      tick();
      drive(1'b0, 24'h0, 16'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush2_tstrb", 128'(m_axis_tstrb), 128'h000C);
      check("flush2_tdata", m_axis_tdata, 128'h8888_0000);
      tick();
      check("flush_lines", 128'(lines_emitted), 128'd7);

      // 6b: reset with a partial line buffered
      drive(1'b1, 24'h50, 16'h0050); tick();
      drive(1'b1, 24'h51, 16'h0051); tick();
      drive(1'b1, 24'h52, 16'h0052); tick();
      drive(1'b0, 24'h0, 16'h0);
      beats_before = beats;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check("midrst_lines", 128'(lines_emitted), 128'd0);
      check("midrst_tvalid", 128'(m_axis_tvalid), 128'd0);
      check("midrst_beats", 128'(beats), 128'(beats_before));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
